// File: rtl/dtlb_utlb_xlate_pkg.sv
// Shared TLB definitions for the data-side address bridge and its micro-TLB:
// field widths, segment codes, cache attribute encoding, FSM states and the
// exception flag bundle.
package dtlb_utlb_xlate_pkg;

  // VPN2 occupies vaddr[31:13], the odd-page select is vaddr[12],
  // and the PFN supplies paddr[31:12].
  localparam int VPN2_WD = 19;
  localparam int PFN_WD  = 20;

  // Segment codes on vaddr[31:28]
  localparam logic [3:0] KSEG0_LO = 4'h8;
  localparam logic [3:0] KSEG0_HI = 4'h9;
  localparam logic [3:0] KSEG1_LO = 4'hA;
  localparam logic [3:0] KSEG1_HI = 4'hB;

  localparam logic [2:0] CACHE_UNCACHED = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

  typedef struct packed {
    logic refill_l;
    logic refill_s;
    logic invalid_l;
    logic invalid_s;
    logic mod;
  } xflags_t;

  function automatic logic is_kseg0(input logic [3:0] seg);
    return (seg == KSEG0_LO) || (seg == KSEG0_HI);
  endfunction

  function automatic logic is_kseg1(input logic [3:0] seg);
    return (seg == KSEG1_LO) || (seg == KSEG1_HI);
  endfunction

endpackage

// File: rtl/dtlb_utlb_xlate_if.sv
// MEM0 <-> translation unit request/response bus.
// master = MEM0 side, slave = translation unit.
interface dtlb_utlb_xlate_if;
  import dtlb_utlb_xlate_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] vaddr;
  logic        is_load;
  logic        is_store;
  logic        is_cache;
  logic        resp_valid;
  logic [31:0] paddr;
  logic        uncached;
  logic        tlb_refill_l;
  logic        tlb_refill_s;
  logic        tlb_invalid_l;
  logic        tlb_invalid_s;
  logic        tlb_mod;

  modport master (
    output req_valid, vaddr, is_load, is_store, is_cache,
    input  req_ready, resp_valid, paddr, uncached,
           tlb_refill_l, tlb_refill_s, tlb_invalid_l, tlb_invalid_s, tlb_mod
  );

  modport slave (
    input  req_valid, vaddr, is_load, is_store, is_cache,
    output req_ready, resp_valid, paddr, uncached,
           tlb_refill_l, tlb_refill_s, tlb_invalid_l, tlb_invalid_s, tlb_mod
  );

endinterface

// File: rtl/dtlb_utlb_xlate_utlb_cam.sv
// Fully-associative micro-TLB storage: parallel VPN match, one-hot to index
// read-out, fill at a round-robin pointer and a single-cycle flush of all
// valid bits (flush leaves the pointer where it is).
module utlb_cam
  import dtlb_utlb_xlate_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = VPN2_WD + 1,
  parameter int PFN_W   = PFN_WD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             hit,
  output logic [PFN_W-1:0] hit_pfn,
  output logic             hit_d,
  output logic [2:0]       hit_c,
  input  logic             fill,
  input  logic [VPN_W-1:0] fill_vpn,
  input  logic [PFN_W-1:0] fill_pfn,
  input  logic             fill_d,
  input  logic [2:0]       fill_c,
  input  logic             flush
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] match;
  logic [VPN_W-1:0]   vpn_q [ENTRIES];
  logic [PFN_W-1:0]   pfn_q [ENTRIES];
  logic               d_q   [ENTRIES];
  logic [2:0]         c_q   [ENTRIES];
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   hit_idx;

  // Compare the lookup VPN against every valid entry in parallel.
  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid_q[i] && (vpn_q[i] == lookup_vpn);
    end
  end

  // Encode the (at most one-hot) match vector into a read index.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match[i]) hit_idx = hit_idx | IDX_W'(i);
    end
  end

  assign hit     = |match;
  assign hit_pfn = pfn_q[hit_idx];
  assign hit_d   = d_q[hit_idx];
  assign hit_c   = c_q[hit_idx];

  // Valid bits and replacement pointer; flush wins over a same-cycle fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[ptr_q] <= 1'b1;
      ptr_q          <= (ptr_q == IDX_W'(ENTRIES - 1)) ? '0 : ptr_q + IDX_W'(1);
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill) begin
      vpn_q[ptr_q] <= fill_vpn;
      pfn_q[ptr_q] <= fill_pfn;
      d_q[ptr_q]   <= fill_d;
      c_q[ptr_q]   <= fill_c;
    end
  end

endmodule

// File: rtl/dtlb_utlb_xlate.sv
// Data-side address bridge between MEM0 and the main TLB with a micro-TLB.
// kseg0/kseg1 and uTLB hits answer one cycle after acceptance; a uTLB miss
// searches the main TLB s1 port (LOOKUP -> RESOLVE) and answers after three.
// Optional macro UTLB_PERF_COUNT_EN adds saturating mapped hit/miss counters.
module dtlb_utlb_xlate
  import dtlb_utlb_xlate_pkg::*;
#(
  parameter int UTLB_ENTRIES = 4,
  parameter int PFN_W        = PFN_WD,
  parameter int VPN2_W       = VPN2_WD
) (
  input  logic                clk,
  input  logic                reset,
  dtlb_utlb_xlate_if.slave    bus,
  output logic [VPN2_W-1:0]   s1_vpn2,
  output logic                s1_odd_page,
  input  logic                s1_found,
  input  logic                s1_d,
  input  logic                s1_v,
  input  logic [2:0]          s1_c,
  input  logic [PFN_W-1:0]    s1_pfn,
  input  logic                utlb_flush
`ifdef UTLB_PERF_COUNT_EN
  ,
  output logic [31:0]         perf_hit_cnt,
  output logic [31:0]         perf_miss_cnt
`endif
);

  localparam int VPN_W = VPN2_W + 1;

  function automatic logic [31:0] make_paddr(input logic [PFN_W-1:0] pfn,
                                             input logic [11:0] off);
    logic [PFN_W+11:0] full;
    full = {pfn, off};
    return 32'(full);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] miss_vaddr;
  logic        miss_store;
  logic        latch;
  logic        fill;

  logic        resp_valid_d, resp_valid_p1;
  logic [31:0] paddr_d, paddr_p1;
  logic        uncached_d, uncached_p1;
  xflags_t     flags_d, flags_p1;

  logic             cam_hit;
  logic [PFN_W-1:0] hit_pfn;
  logic             hit_d;
  logic [2:0]       hit_c;

  logic [3:0] seg;
  logic       kseg1;
  logic       unmapped;
  logic       accept;
  logic       req_store;

  assign seg       = bus.vaddr[31:28];
  assign kseg1     = is_kseg1(seg);
  assign unmapped  = is_kseg0(seg) || kseg1;
  assign accept    = bus.req_valid && (state_q == ST_IDLE);
  assign req_store = bus.is_store && !(bus.is_load || bus.is_cache);

  utlb_cam #(
    .ENTRIES (UTLB_ENTRIES),
    .VPN_W   (VPN_W),
    .PFN_W   (PFN_W)
  ) u_cam (
    .clk        (clk),
    .reset      (reset),
    .lookup_vpn (bus.vaddr[31 -: VPN_W]),
    .hit        (cam_hit),
    .hit_pfn    (hit_pfn),
    .hit_d      (hit_d),
    .hit_c      (hit_c),
    .fill       (fill),
    .fill_vpn   (miss_vaddr[31 -: VPN_W]),
    .fill_pfn   (s1_pfn),
    .fill_d     (s1_d),
    .fill_c     (s1_c),
    .flush      (utlb_flush)
  );

  // Next state, uTLB fill and the response to register this cycle.
  always_comb begin
    state_d      = state_q;
    latch        = 1'b0;
    fill         = 1'b0;
    resp_valid_d = 1'b0;
    paddr_d      = '0;
    uncached_d   = 1'b0;
    flags_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (unmapped) begin
            resp_valid_d = 1'b1;
            paddr_d      = {3'b000, bus.vaddr[28:0]};
            uncached_d   = kseg1;
          end else if (cam_hit) begin
            resp_valid_d = 1'b1;
            paddr_d      = make_paddr(hit_pfn, bus.vaddr[11:0]);
            uncached_d   = (hit_c == CACHE_UNCACHED);
            flags_d.mod  = req_store && !hit_d;
          end else begin
            latch   = 1'b1;
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        // A flush here just repeats the search from the latched address.
        state_d = utlb_flush ? ST_LOOKUP : ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (utlb_flush) begin
          // Main TLB is being rewritten: drop this result and search again.
          state_d = ST_LOOKUP;
        end else begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          if (!s1_found) begin
            flags_d.refill_s = miss_store;
            flags_d.refill_l = !miss_store;
          end else if (!s1_v) begin
            flags_d.invalid_s = miss_store;
            flags_d.invalid_l = !miss_store;
          end else begin
            fill        = 1'b1;
            paddr_d     = make_paddr(s1_pfn, miss_vaddr[11:0]);
            uncached_d  = (s1_c == CACHE_UNCACHED);
            flags_d.mod = miss_store && !s1_d;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and the registered response; reset drops any pending miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      resp_valid_p1 <= 1'b0;
      paddr_p1      <= '0;
      uncached_p1   <= 1'b0;
      flags_p1      <= '0;
    end else begin
      state_q       <= state_d;
      resp_valid_p1 <= resp_valid_d;
      paddr_p1      <= paddr_d;
      uncached_p1   <= uncached_d;
      flags_p1      <= flags_d;
    end
  end

  // Hold the missing request for the main-TLB search and the eventual fill.
  always_ff @(posedge clk) begin
    if (latch) begin
      miss_vaddr <= bus.vaddr;
      miss_store <= req_store;
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.resp_valid    = resp_valid_p1;
  assign bus.paddr         = paddr_p1;
  assign bus.uncached      = uncached_p1;
  assign bus.tlb_refill_l  = flags_p1.refill_l;
  assign bus.tlb_refill_s  = flags_p1.refill_s;
  assign bus.tlb_invalid_l = flags_p1.invalid_l;
  assign bus.tlb_invalid_s = flags_p1.invalid_s;
  assign bus.tlb_mod       = flags_p1.mod;

  assign s1_vpn2     = (state_q == ST_LOOKUP) ? miss_vaddr[31 -: VPN2_W] : '0;
  assign s1_odd_page = (state_q == ST_LOOKUP) && miss_vaddr[31 - VPN2_W];

`ifdef UTLB_PERF_COUNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Mapped hit/miss counters, sampled at acceptance and saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (accept && !unmapped) begin
      if (cam_hit) perf_hit_cnt  <= sat_inc(perf_hit_cnt);
      else         perf_miss_cnt <= sat_inc(perf_miss_cnt);
    end
  end
`else
  // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_dtlb_utlb_xlate.sv
// Directed bench for dtlb_utlb_xlate (UTLB_ENTRIES = 4).
module tb_dtlb_utlb_xlate;

  logic        clk;
  logic        reset;
  logic [18:0] s1_vpn2;
  logic        s1_odd_page;
  logic        s1_found;
  logic        s1_d;
  logic        s1_v;
  logic [2:0]  s1_c;
  logic [19:0] s1_pfn;
  logic        utlb_flush;
`ifdef UTLB_PERF_COUNT_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] F_REFILL_L  = 32'd16;
  localparam logic [31:0] F_REFILL_S  = 32'd8;
  localparam logic [31:0] F_INVALID_L = 32'd4;
  localparam logic [31:0] F_MOD       = 32'd1;

  dtlb_utlb_xlate_if bus();

  dtlb_utlb_xlate #(
    .UTLB_ENTRIES (4),
    .PFN_W        (20),
    .VPN2_W       (19)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .s1_vpn2     (s1_vpn2),
    .s1_odd_page (s1_odd_page),
    .s1_found    (s1_found),
    .s1_d        (s1_d),
    .s1_v        (s1_v),
    .s1_c        (s1_c),
    .s1_pfn      (s1_pfn),
    .utlb_flush  (utlb_flush)
`ifdef UTLB_PERF_COUNT_EN
    ,
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {27'b0, bus.tlb_refill_l, bus.tlb_refill_s, bus.tlb_invalid_l,
            bus.tlb_invalid_s, bus.tlb_mod};
  endfunction

  // Present one request for exactly one accepting edge.
  task automatic issue(input logic [31:0] va, input logic st);
    bus.req_valid = 1'b1;
    bus.vaddr     = va;
    bus.is_store  = st;
    bus.is_load   = !st;
    bus.is_cache  = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    bus.is_load   = 1'b0;
    bus.is_store  = 1'b0;
  endtask

  // Called in LOOKUP: answer the s1 search and advance to the response cycle.
  task automatic serve(input string tag, input logic found, input logic v, input logic d,
                       input logic [2:0] c, input logic [19:0] pfn);
    chk1({tag, " lookup resp_valid"}, bus.resp_valid, 1'b0);
    chk1({tag, " lookup ready"}, bus.req_ready, 1'b0);
    s1_found = found; s1_v = v; s1_d = d; s1_c = c; s1_pfn = pfn;
    tick();
    chk1({tag, " resolve resp_valid"}, bus.resp_valid, 1'b0);
    tick();
    s1_found = 1'b0; s1_v = 1'b0; s1_d = 1'b0; s1_c = 3'd0; s1_pfn = '0;
    chk1({tag, " resp_valid"}, bus.resp_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.vaddr = '0;
    bus.is_load = 1'b0; bus.is_store = 1'b0; bus.is_cache = 1'b0;
    s1_found = 1'b0; s1_v = 1'b0; s1_d = 1'b0; s1_c = 3'd0; s1_pfn = '0;
    utlb_flush = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk1("rst ready", bus.req_ready, 1'b1);
    chk1("rst resp_valid", bus.resp_valid, 1'b0);
    chk32("rst paddr", bus.paddr, 32'h0);
    chk32("rst flags", flags(), 32'h0);
    chk32("rst s1_vpn2", 32'(s1_vpn2), 32'h0);

    // Unmapped, back to back
    issue(32'h8000_1234, 1'b0);
    chk1("kseg0 resp_valid", bus.resp_valid, 1'b1);
    chk32("kseg0 paddr", bus.paddr, 32'h0000_1234);
    chk1("kseg0 uncached", bus.uncached, 1'b0);
    issue(32'hA000_0010, 1'b0);
    chk1("kseg1 resp_valid", bus.resp_valid, 1'b1);
    chk32("kseg1 paddr", bus.paddr, 32'h0000_0010);
    chk1("kseg1 uncached", bus.uncached, 1'b1);
    chk32("kseg1 flags", flags(), 32'h0);
    tick();
    chk1("pulse end", bus.resp_valid, 1'b0);

    // Miss then hit
    issue(32'h0040_2008, 1'b0);
    chk32("miss s1_vpn2", 32'(s1_vpn2), 32'h201);
    chk1("miss s1_odd", s1_odd_page, 1'b0);
    serve("miss", 1'b1, 1'b1, 1'b1, 3'd3, 20'h12345);
    chk32("miss paddr", bus.paddr, 32'h1234_5008);
    chk1("miss uncached", bus.uncached, 1'b0);
    chk32("miss flags", flags(), 32'h0);
    chk1("miss ready after", bus.req_ready, 1'b1);
    issue(32'h0040_2008, 1'b0);
    chk1("hit resp_valid", bus.resp_valid, 1'b1);
    chk32("hit paddr", bus.paddr, 32'h1234_5008);
    chk32("hit s1_vpn2 idle", 32'(s1_vpn2), 32'h0);

    // Exceptions
    issue(32'h0050_3000, 1'b1);
    serve("refill_s", 1'b0, 1'b0, 1'b0, 3'd0, 20'h0);
    chk32("refill_s flags", flags(), F_REFILL_S);
    issue(32'h0060_1004, 1'b0);
    serve("invalid_l", 1'b1, 1'b0, 1'b1, 3'd3, 20'h00ABC);
    chk32("invalid_l flags", flags(), F_INVALID_L);
    issue(32'h0060_1004, 1'b0);
    chk1("invalid no fill", bus.resp_valid, 1'b0);
    serve("fill_uc", 1'b1, 1'b1, 1'b0, 3'd2, 20'h00ABC);
    chk32("fill_uc paddr", bus.paddr, 32'h00AB_C004);
    chk1("fill_uc uncached", bus.uncached, 1'b1);
    chk32("fill_uc flags", flags(), 32'h0);
    issue(32'h0060_1FFC, 1'b1);
    chk1("mod resp_valid", bus.resp_valid, 1'b1);
    chk32("mod flags", flags(), F_MOD);
    issue(32'h0040_2008, 1'b1);
    chk32("store dirty flags", flags(), 32'h0);
    chk32("store dirty paddr", bus.paddr, 32'h1234_5008);

    // Flush during RESOLVE re-searches with fresh s1 data
    issue(32'h0070_0000, 1'b0);
    chk32("fr s1_vpn2", 32'(s1_vpn2), 32'h380);
    s1_found = 1'b1; s1_v = 1'b1; s1_d = 1'b1; s1_c = 3'd3; s1_pfn = 20'h11111;
    tick();
    utlb_flush = 1'b1;
    tick();
    utlb_flush = 1'b0;
    chk1("fr relookup ready", bus.req_ready, 1'b0);
    chk32("fr relookup s1_vpn2", 32'(s1_vpn2), 32'h380);
    s1_pfn = 20'h22222;
    serve("fr", 1'b1, 1'b1, 1'b1, 3'd3, 20'h22222);
    chk32("fr paddr", bus.paddr, 32'h2222_2000);
    issue(32'h0070_0000, 1'b0);
    chk1("fr hit", bus.resp_valid, 1'b1);
    chk32("fr hit paddr", bus.paddr, 32'h2222_2000);

    // Flush in IDLE: same-cycle request still hits, next one misses
    utlb_flush = 1'b1;
    issue(32'h0070_0000, 1'b0);
    utlb_flush = 1'b0;
    chk1("fi same-cycle hit", bus.resp_valid, 1'b1);
    chk32("fi same-cycle paddr", bus.paddr, 32'h2222_2000);
    issue(32'h0070_0000, 1'b0);
    chk1("fi after miss", bus.resp_valid, 1'b0);
    serve("fi", 1'b0, 1'b0, 1'b0, 3'd0, 20'h0);
    chk32("fi refill_l", flags(), F_REFILL_L);

    // Reset during LOOKUP
    issue(32'h0040_2008, 1'b0);
    serve("pre_rst", 1'b1, 1'b1, 1'b1, 3'd3, 20'h12345);
    issue(32'h0040_2008, 1'b0);
    chk1("pre_rst hit", bus.resp_valid, 1'b1);
    issue(32'h0080_0000, 1'b0);
    chk1("mid_rst lookup ready", bus.req_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk1("mid_rst ready", bus.req_ready, 1'b1);
    chk32("mid_rst s1_vpn2", 32'(s1_vpn2), 32'h0);
    tick();
    chk1("mid_rst resp_valid", bus.resp_valid, 1'b0);
    reset = 1'b0;
    tick();
    chk1("post_rst resp_valid", bus.resp_valid, 1'b0);
    tick();
    chk1("post_rst resp_valid2", bus.resp_valid, 1'b0);
    issue(32'h0040_2008, 1'b0);
    chk1("post_rst entries invalid", bus.resp_valid, 1'b0);
    serve("post_rst", 1'b0, 1'b0, 1'b0, 3'd0, 20'h0);
    chk32("post_rst refill_l", flags(), F_REFILL_L);

    // Replacement: five distinct pages through four entries from pointer 0
    for (int i = 0; i < 5; i++) begin
      issue(32'h0100_0000 + (32'(i) << 12), 1'b0);
      chk1($sformatf("repl fill%0d miss", i), bus.resp_valid, 1'b0);
      serve($sformatf("repl fill%0d", i), 1'b1, 1'b1, 1'b1, 3'd3, 20'h00100 + 20'(i));
      chk32($sformatf("repl fill%0d paddr", i), bus.paddr, 32'h0010_0000 + (32'(i) << 12));
    end
    for (int i = 1; i < 5; i++) begin
      issue(32'h0100_0000 + (32'(i) << 12), 1'b0);
      chk1($sformatf("repl hit%0d", i), bus.resp_valid, 1'b1);
      chk32($sformatf("repl hit%0d paddr", i), bus.paddr, 32'h0010_0000 + (32'(i) << 12));
    end
    issue(32'h0100_0000, 1'b0);
    chk1("repl first evicted", bus.resp_valid, 1'b0);
    serve("repl refill0", 1'b1, 1'b1, 1'b1, 3'd3, 20'h00200);
    chk32("repl refill0 paddr", bus.paddr, 32'h0020_0000);
    issue(32'h0100_1000, 1'b0);
    chk1("repl ptr wrapped to 1", bus.resp_valid, 1'b0);
    serve("repl p1", 1'b0, 1'b0, 1'b0, 3'd0, 20'h0);
    chk32("repl p1 refill_l", flags(), F_REFILL_L);
    issue(32'h0100_2000, 1'b0);
    chk1("repl p2 hit", bus.resp_valid, 1'b1);
    chk32("repl p2 paddr", bus.paddr, 32'h0010_2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
